router_pkt_reg: RTL

Parametrised packet register for the router datapath: captures the header, steers header/payload/held bytes to the output FIFO bus, and accumulates an internal check value (XOR parity or modulo-sum checksum) to compare against the trailing check byte. It also checks payload length against the header length field and keeps a saturating per-block error counter. It sits between the input port and the channel FIFOs, driven by the router FSM state strobes (detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg).

---
 rtl/router_pkg.sv | 28 ++
 rtl/router_chk_acc.sv | 53 +++++
 rtl/router_pkt_reg.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
//   Shared definitions for the router packet datapath.
//   - CHK_XOR / CHK_SUM : check-value accumulation modes
//   - DEF_*             : default byte, address and channel geometry
//   - chk_acc()         : one accumulation step, XOR parity or modular sum
// ---------------------------------------------------------------------------
package router_pkg;

   localparam int CHK_XOR    = 0;
   localparam int CHK_SUM    = 1;

   localparam int DEF_DW     = 8;
   localparam int DEF_ADDR_W = 2;
   localparam int DEF_NUM_CH = 3;

   // Widest byte the helper handles. Callers truncate the result to their
   // own width, which makes the sum wrap modulo 2^DW.
   localparam int ACC_W = 32;
   typedef logic [ACC_W-1:0] acc_word_t;

   function automatic acc_word_t chk_acc(input int mode, input acc_word_t a,
                                         input acc_word_t b);
      if (mode == CHK_SUM) return a + b;
      else                 return a ^ b;
   endfunction

endpackage

// File: rtl/router_chk_acc.sv
// ---------------------------------------------------------------------------
// router_chk_acc
//   Running check value and payload byte counter for one packet.
//   Ports:
//     clock, resetn   system clock, synchronous active-low reset
//     chk_clr         zero the check value (new header cycle)
//     acc_en          fold acc_data into the check value
//     acc_data        byte to fold in
//     len_clr         zero the payload counter (accepted header)
//     len_inc         count one payload byte
//     int_chk         accumulated check value
//     count           payload byte count, saturating at all-ones
// ---------------------------------------------------------------------------
module router_chk_acc
   import router_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int LEN_W    = DEF_DW - DEF_ADDR_W,
   parameter int CHK_MODE = CHK_XOR
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             chk_clr,
   input  logic             acc_en,
   input  logic [DW-1:0]    acc_data,
   input  logic             len_clr,
   input  logic             len_inc,
   output logic [DW-1:0]    int_chk,
   output logic [LEN_W:0]   count
);

   // NOTE: reset is sampled on the clock edge (synchronous), and all state
   // updates use non-blocking assignments so every register sees the
   // pre-edge values of its neighbours.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         int_chk <= '0;
         count   <= '0;
      end else begin
         if (chk_clr)
            int_chk <= '0;
         else if (acc_en)
            int_chk <= DW'(chk_acc(CHK_MODE, acc_word_t'(int_chk),
                                   acc_word_t'(acc_data)));

         if (len_clr)
            count <= '0;
         else if (len_inc && (count != '1))
            count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/router_pkt_reg.sv
// ---------------------------------------------------------------------------
// router_pkt_reg
//   Packet register between the input port and the channel FIFOs. Latches a
//   valid header, steers header / payload / held bytes onto dout, checks the
//   trailing check byte against an accumulated check value, checks payload
//   length against the header length field and counts bad packets.
//   Ports:
//     clock, resetn        system clock, synchronous active-low reset
//     pkt_valid            source is presenting packet bytes (low on check)
//     data_in              input byte
//     fifo_full            selected channel FIFO is full
//     detect_add .. rst_int_reg   one-hot FSM state strobes
//     cnt_clr              clear err_cnt
//     dout                 byte to the FIFO
//     parity_done          check byte has been received
//     low_pkt_valid        pkt_valid dropped while loading
//     err                  check value mismatch
//     len_err              payload count differs from header length
//     err_cnt              saturating count of packets with err or len_err
// ---------------------------------------------------------------------------
module router_pkt_reg
   import router_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_CH   = DEF_NUM_CH,
   parameter int CHK_MODE = CHK_XOR,
   parameter int CNT_W    = 8
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             pkt_valid,
   input  logic [DW-1:0]    data_in,
   input  logic             fifo_full,
   input  logic             detect_add,
   input  logic             lfd_state,
   input  logic             ld_state,
   input  logic             laf_state,
   input  logic             full_state,
   input  logic             rst_int_reg,
   input  logic             cnt_clr,
   output logic [DW-1:0]    dout,
   output logic             parity_done,
   output logic             low_pkt_valid,
   output logic             err,
   output logic             len_err,
   output logic [CNT_W-1:0] err_cnt
);

   localparam int LEN_W = DW - ADDR_W;

   logic [DW-1:0]    header;
   logic [DW-1:0]    hold;
   logic             hold_pl;
   logic [DW-1:0]    pkt_chk;
   logic             done_q;

   logic             hdr_ok;
   logic [LEN_W-1:0] hdr_len;
   logic             pd_set;
   logic             eval;
   logic             chk_bad;
   logic             len_bad;

   logic             acc_en;
   logic [DW-1:0]    acc_data;
   logic             len_inc;
   logic [DW-1:0]    int_chk;
   logic [LEN_W:0]   count;

   // full_state has no effect here: FIFO back-pressure arrives via fifo_full.
   logic unused_full_state;
   assign unused_full_state = full_state;

   assign hdr_ok  = pkt_valid & detect_add &
                    (32'(data_in[ADDR_W-1:0]) < NUM_CH);
   assign hdr_len = header[DW-1:ADDR_W];

   // Check byte seen directly, or a check byte parked in hold is drained.
   assign pd_set  = (ld_state & !fifo_full & !pkt_valid) |
                    (laf_state & low_pkt_valid & !parity_done);

   assign chk_bad = (int_chk != pkt_chk);
   assign len_bad = (count != {1'b0, hdr_len});
   assign eval    = parity_done & !done_q;

   // Select what feeds the check value this cycle: header on lfd, a live
   // payload byte on ld, or a payload byte that was parked during fifo_full.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // can leave one unassigned and infer a latch.
      acc_en   = 1'b0;
      acc_data = '0;
      len_inc  = 1'b0;
      if (lfd_state) begin
         acc_en   = 1'b1;
         acc_data = header;
      end else if (ld_state & pkt_valid & !fifo_full) begin
         acc_en   = 1'b1;
         acc_data = data_in;
         len_inc  = 1'b1;
      end else if (laf_state & hold_pl) begin
         acc_en   = 1'b1;
         acc_data = hold;
         len_inc  = 1'b1;
      end
   end

   router_chk_acc #(
      .DW       (DW),
      .LEN_W    (LEN_W),
      .CHK_MODE (CHK_MODE)
   ) u_chk_acc (
      .clock    (clock),
      .resetn   (resetn),
      .chk_clr  (detect_add),
      .acc_en   (acc_en),
      .acc_data (acc_data),
      .len_clr  (hdr_ok),
      .len_inc  (len_inc),
      .int_chk  (int_chk),
      .count    (count)
   );

   always_ff @(posedge clock) begin
      if (!resetn) begin
         header        <= '0;
         hold          <= '0;
         hold_pl       <= 1'b0;
         dout          <= '0;
         pkt_chk       <= '0;
         parity_done   <= 1'b0;
         low_pkt_valid <= 1'b0;
         err           <= 1'b0;
         len_err       <= 1'b0;
         done_q        <= 1'b0;
         err_cnt       <= '0;
      end else begin
         if (hdr_ok)
            header <= data_in;

         if (lfd_state)
            dout <= header;
         else if (ld_state & !fifo_full)
            dout <= data_in;
         else if (ld_state & fifo_full) begin
            hold    <= data_in;
            hold_pl <= pkt_valid;
         end else if (laf_state)
            dout <= hold;

         // Only the first byte after pkt_valid falls is the check byte.
         if (detect_add)
            pkt_chk <= '0;
         else if (ld_state & !pkt_valid & !low_pkt_valid)
            pkt_chk <= data_in;

         if (pd_set)
            parity_done <= 1'b1;
         else if (hdr_ok)
            parity_done <= 1'b0;

         if (rst_int_reg)
            low_pkt_valid <= 1'b0;
         else if (ld_state & !pkt_valid)
            low_pkt_valid <= 1'b1;

         err     <= parity_done & chk_bad;
         len_err <= parity_done & len_bad;
         done_q  <= parity_done;

         // Judge each packet once, on the first cycle parity_done is high.
         if (cnt_clr)
            err_cnt <= '0;
         else if (eval & (chk_bad | len_bad) & (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
      end
   end

endmodule
